// File: rtl/gpio_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_debounce
//  Description : Per-pin pad glitch filter placed in front of the GPIO
//                peripheral input. A pin's filtered level only changes once
//                its sampled input has differed from it for filt_len+1
//                prescaled ticks. One-cycle rise/fall pulses accompany every
//                filtered level change.
//  Build macro : GPIO_DEBOUNCE_SYNC_EN - when defined, each pad passes through
//                a 2-FF synchroniser before filtering; when undefined, pad_in
//                is used directly and must already be synchronous to HCLK.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_debounce #(
    parameter int NUM_PINS    = 32,
    parameter int CNT_WIDTH   = 8,
    parameter int PRESC_WIDTH = 16
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_PINS-1:0]    pad_in,
    input  logic [NUM_PINS-1:0]    filt_en,
    input  logic [CNT_WIDTH-1:0]   filt_len,
    input  logic [PRESC_WIDTH-1:0] presc,
    output logic [NUM_PINS-1:0]    gpio_filt,
    output logic [NUM_PINS-1:0]    rise_evt,
    output logic [NUM_PINS-1:0]    fall_evt
);

    logic [PRESC_WIDTH-1:0] r_presc;
    logic                   w_tick;
    logic [NUM_PINS-1:0]    w_s;

    // Tick on the last count of the shared divider window.
    assign w_tick = (r_presc == presc);

    // Shared prescaler: counts 0..presc; if presc drops below the current
    // count it simply runs on and wraps at the natural register overflow.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

`ifdef GPIO_DEBOUNCE_SYNC_EN
    logic [NUM_PINS-1:0] r_sync1;
    logic [NUM_PINS-1:0] r_sync2;

    // Two-stage synchroniser bringing the asynchronous pads into HCLK.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= pad_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = pad_in;
`endif

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
        logic [CNT_WIDTH-1:0] r_cnt;
        logic                 r_filt;
        logic                 r_rise;
        logic                 r_fall;

        // Stability counter and filtered level; the counter is cleared
        // whenever the sample agrees with the filtered level, so a glitch
        // shorter than the window always restarts the count. Because the
        // accept test is >=, cnt never passes filt_len and cannot wrap.
        always_ff @(posedge HCLK or posedge HRESET) begin
            if (HRESET) begin
                r_cnt  <= '0;
                r_filt <= 1'b0;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else if (!filt_en[i]) begin
                r_cnt  <= '0;
                r_filt <= w_s[i];
                r_rise <= w_s[i] & ~r_filt;
                r_fall <= ~w_s[i] & r_filt;
            end else if (w_s[i] == r_filt) begin
                r_cnt  <= '0;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else if (w_tick) begin
                if (r_cnt >= filt_len) begin
                    r_cnt  <= '0;
                    r_filt <= w_s[i];
                    r_rise <= w_s[i];
                    r_fall <= ~w_s[i];
                end else begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end
        end

        assign gpio_filt[i] = r_filt;
        assign rise_evt[i]  = r_rise;
        assign fall_evt[i]  = r_fall;
    end

endmodule
`default_nettype wire

// File: tb/tb_gpio_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_debounce
//  Description : Self-checking bench for gpio_debounce. Expected edge events
//                are queued with their due cycle as stimulus is applied; a
//                monitor pops and compares them as the DUT pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_debounce;

`ifdef GPIO_DEBOUNCE_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    typedef struct {
        int cyc;
        int pin;
        bit rise;
    } exp_t;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [31:0] pad_in = '0;
    logic [31:0] filt_en = '0;
    logic [7:0]  filt_len = 8'd3;
    logic [15:0] presc = '0;
    logic [31:0] gpio_filt;
    logic [31:0] rise_evt;
    logic [31:0] fall_evt;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [15:0] mp;

    gpio_debounce #(.NUM_PINS(32), .CNT_WIDTH(8), .PRESC_WIDTH(16)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .pad_in    (pad_in),
        .filt_en   (filt_en),
        .filt_len  (filt_len),
        .presc     (presc),
        .gpio_filt (gpio_filt),
        .rise_evt  (rise_evt),
        .fall_evt  (fall_evt)
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cyc <= cyc + 1;

    // Reference tick phase: tick on the edge where the phase equals presc.
    always @(posedge HCLK or posedge HRESET) begin
        if (HRESET)          mp <= '0;
        else if (mp == presc) mp <= '0;
        else                 mp <= mp + 16'd1;
    end

    // Cycle at which the n-th tick, counted from edge c+first_off onward,
    // commits. Called at a negedge where cyc == c.
    function automatic int exp_cycle(int c, int first_off, int n_ticks);
        int p;
        int n;
        p = int'(mp);
        n = 0;
        for (int e = c + 1; e < c + 100000; e++) begin
            if (p == int'(presc)) begin
                if (e >= c + first_off) begin
                    n++;
                    if (n == n_ticks) return e;
                end
                p = 0;
            end else begin
                p = (p + 1) % 65536;
            end
        end
        return -1;
    endfunction

    // Event monitor: every pulse must match the head of the scoreboard.
    always @(negedge HCLK) begin
        if (!HRESET) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_checks++;
                n_err++;
                $display("FAIL missing_evt pin %0d rise=%0d: expected at cycle %0d, still absent at cycle %0d",
                         sb[0].pin, sb[0].rise, sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
            for (int i = 0; i < 32; i++) begin
                if (rise_evt[i] || fall_evt[i]) begin
                    n_checks++;
                    if (rise_evt[i] && fall_evt[i]) begin
                        n_err++;
                        $display("FAIL both_evt pin %0d cycle %0d: rise=1 fall=1, required only one", i, cyc);
                    end else if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_evt pin %0d cycle %0d rise=%0d: required no event", i, cyc, rise_evt[i]);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        if (e.cyc !== cyc || e.pin !== i || e.rise !== rise_evt[i]) begin
                            n_err++;
                            $display("FAIL evt: got pin %0d rise=%0d cycle %0d, required pin %0d rise=%0d cycle %0d",
                                     i, rise_evt[i], cyc, e.pin, e.rise, e.cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge HCLK);
    endtask

    task automatic do_reset(input logic [31:0] en);
        @(negedge HCLK);
        HRESET  = 1'b1;
        pad_in  = '0;
        filt_en = en;
        @(negedge HCLK);
        HRESET = 1'b0;
        @(negedge HCLK);
    endtask

    task automatic test_reset;
        int c;
        pad_in  = '1;
        filt_en = '0;
        HRESET  = 1'b1;
        @(negedge HCLK);
        @(negedge HCLK);
        n_checks++;
        if (gpio_filt !== 32'h0) begin n_err++; $display("FAIL reset_filt: got %h, required 00000000", gpio_filt); end
        n_checks++;
        if (rise_evt !== 32'h0) begin n_err++; $display("FAIL reset_rise: got %h, required 00000000", rise_evt); end
        n_checks++;
        if (fall_evt !== 32'h0) begin n_err++; $display("FAIL reset_fall: got %h, required 00000000", fall_evt); end
        HRESET = 1'b0;
        c = cyc;
        for (int i = 0; i < 32; i++) sb.push_back('{c + SYNC_LAT + 1, i, 1'b1});
        wait_until(c + SYNC_LAT);
        n_checks++;
        if (gpio_filt !== 32'h0) begin n_err++; $display("FAIL reset_early: got %h, required 00000000", gpio_filt); end
        wait_until(c + SYNC_LAT + 1);
        n_checks++;
        if (gpio_filt !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL reset_follow: got %h, required ffffffff", gpio_filt); end
        wait_until(c + SYNC_LAT + 2);
        n_checks++;
        if (rise_evt !== 32'h0) begin n_err++; $display("FAIL reset_pulse_len: got %h, required 00000000", rise_evt); end
    endtask

    task automatic test_filter_accept;
        int c;
        int t;
        do_reset(32'h1);
        filt_len = 8'd3;
        presc    = 16'd0;
        @(negedge HCLK);
        pad_in[0] = 1'b1;
        c = cyc;
        t = exp_cycle(c, SYNC_LAT + 1, 4);
        sb.push_back('{t, 0, 1'b1});
        wait_until(t - 1);
        n_checks++;
        if (gpio_filt[0] !== 1'b0) begin n_err++; $display("FAIL accept_early: got %b, required 0", gpio_filt[0]); end
        wait_until(t);
        n_checks++;
        if (gpio_filt[0] !== 1'b1) begin n_err++; $display("FAIL accept: got %b, required 1", gpio_filt[0]); end
    endtask

    task automatic test_glitch;
        int c;
        int t;
        @(negedge HCLK);
        pad_in[0] = 1'b0;
        repeat (3) @(negedge HCLK);
        pad_in[0] = 1'b1;
        repeat (SYNC_LAT + 5) @(negedge HCLK);
        n_checks++;
        if (gpio_filt[0] !== 1'b1) begin n_err++; $display("FAIL glitch_reject: got %b, required 1", gpio_filt[0]); end
        pad_in[0] = 1'b0;
        c = cyc;
        t = exp_cycle(c, SYNC_LAT + 1, 4);
        sb.push_back('{t, 0, 1'b0});
        wait_until(t - 1);
        n_checks++;
        if (gpio_filt[0] !== 1'b1) begin n_err++; $display("FAIL glitch_restart: got %b, required 1", gpio_filt[0]); end
        wait_until(t);
        n_checks++;
        if (gpio_filt[0] !== 1'b0) begin n_err++; $display("FAIL glitch_accept: got %b, required 0", gpio_filt[0]); end
    endtask

    task automatic test_prescaler;
        int c;
        int t;
        pad_in[5] = 1'b1;
        c = cyc;
        sb.push_back('{c + SYNC_LAT + 1, 5, 1'b1});
        wait_until(c + SYNC_LAT + 3);
        filt_en[5] = 1'b1;
        presc      = 16'd9;
        filt_len   = 8'd1;
        repeat (2) @(negedge HCLK);
        pad_in[5] = 1'b0;
        c = cyc;
        t = exp_cycle(c, SYNC_LAT + 1, 2);
        sb.push_back('{t, 5, 1'b0});
        n_checks++;
        if (t - c > SYNC_LAT + 20) begin n_err++; $display("FAIL presc_window: got %0d cycles, required <= %0d", t - c, SYNC_LAT + 20); end
        wait_until(t - 1);
        n_checks++;
        if (gpio_filt[5] !== 1'b1) begin n_err++; $display("FAIL presc_early: got %b, required 1", gpio_filt[5]); end
        wait_until(t + 3);
        n_checks++;
        if (gpio_filt[5] !== 1'b0) begin n_err++; $display("FAIL presc_fall: got %b, required 0", gpio_filt[5]); end
    endtask

    task automatic test_mixed_reset;
        int c;
        int t;
        do_reset(32'h2);
        filt_len = 8'd200;
        presc    = 16'd0;
        pad_in[1:0] = 2'b11;
        c = cyc;
        sb.push_back('{c + SYNC_LAT + 1, 0, 1'b1});
        wait_until(c + SYNC_LAT + 1);
        n_checks++;
        if (gpio_filt[1:0] !== 2'b01) begin n_err++; $display("FAIL mixed_follow: got %b, required 01", gpio_filt[1:0]); end
        wait_until(c + SYNC_LAT + 100);
        HRESET = 1'b1;
        @(negedge HCLK);
        n_checks++;
        if (gpio_filt !== 32'h0) begin n_err++; $display("FAIL midreset_clear: got %h, required 00000000", gpio_filt); end
        HRESET = 1'b0;
        c = cyc;
        sb.push_back('{c + SYNC_LAT + 1, 0, 1'b1});
        t = exp_cycle(c, SYNC_LAT + 1, 201);
        sb.push_back('{t, 1, 1'b1});
        wait_until(t - 1);
        n_checks++;
        if (gpio_filt[1] !== 1'b0) begin n_err++; $display("FAIL midreset_restart: got %b, required 0", gpio_filt[1]); end
        wait_until(t);
        n_checks++;
        if (gpio_filt[1] !== 1'b1) begin n_err++; $display("FAIL midreset_accept: got %b, required 1", gpio_filt[1]); end
    endtask

    task automatic test_len_lower;
        int c;
        @(negedge HCLK);
        pad_in[1] = 1'b0;
        c = cyc;
        wait_until(c + SYNC_LAT + 50);
        filt_len = 8'd2;
        sb.push_back('{c + SYNC_LAT + 51, 1, 1'b0});
        n_checks++;
        if (gpio_filt[1] !== 1'b1) begin n_err++; $display("FAIL lenlow_hold: got %b, required 1", gpio_filt[1]); end
        wait_until(c + SYNC_LAT + 51);
        n_checks++;
        if (gpio_filt[1] !== 1'b0) begin n_err++; $display("FAIL lenlow_accept: got %b, required 0", gpio_filt[1]); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_filter_accept();
        test_glitch();
        test_prescaler();
        test_mixed_reset();
        test_len_lower();
        repeat (5) @(negedge HCLK);
        n_checks++;
        if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
